// File: rtl/pool_pkg.sv
// Shared types and elaboration-time helpers for the streaming 2-D pooling engine.
package pool_pkg;

  typedef enum logic {POOL_AVG = 1'b0, POOL_MAX = 1'b1} pool_mode_e;

  function automatic int acc_width(input int p, input int kh, input int kw);
    return p + $clog2(kh * kw);
  endfunction

  // round(2^frac / (kh*kw)), half rounded up
  function automatic longint recip_const(input int kh, input int kw, input int frac);
    longint n;
    n = longint'(kh * kw);
    return ((longint'(1) << frac) + n / 2) / n;
  endfunction

  function automatic longint sat_signed(input longint v, input int p);
    longint hi, lo;
    hi = (longint'(1) << (p - 1)) - 1;
    lo = -(longint'(1) << (p - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pool_window_reduce.sv
// One channel of the pooling datapath: folds a pixel into its window partial and
// produces the finalised (averaged or max) pixel from the folded value.
module pool_window_reduce
  import pool_pkg::*;
#(
  parameter int     P          = 8,
  parameter int     ACC_W      = 10,
  parameter int     MODE       = 0,
  parameter int     RECIP_FRAC = 16,
  parameter longint RECIP      = 16384
) (
  input  logic [P-1:0]     pix,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             first,
  output logic [ACC_W-1:0] acc_out,
  output logic [P-1:0]     res
);

  localparam int MW = ACC_W + RECIP_FRAC + 2;
  localparam int QW = MW - RECIP_FRAC;
  localparam logic signed [MW-1:0] RECIP_C = MW'(RECIP);
  localparam logic signed [MW-1:0] HALF    = MW'(longint'(1) << (RECIP_FRAC - 1));

  logic signed [ACC_W-1:0] pix_ext, acc_s, comb;
  logic signed [MW-1:0]    prod;
  logic signed [QW-1:0]    quo;

  always_comb begin
    pix_ext = ACC_W'($signed(pix));
    acc_s   = $signed(acc_in);
    if (first)                          comb = pix_ext;
    else if (MODE == int'(POOL_MAX))    comb = (pix_ext > acc_s) ? pix_ext : acc_s;
    else                                comb = acc_s + pix_ext;
    // sum * (1/N) in fixed point; adding half before the arithmetic shift rounds toward +inf
    prod = MW'(comb) * RECIP_C + HALF;
    quo  = QW'(prod >>> RECIP_FRAC);
    if (MODE == int'(POOL_MAX)) res = comb[P-1:0];
    else                        res = P'(sat_signed(longint'(quo), P));
  end

  assign acc_out = comb;

endmodule

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping 2-D pooling: raster pixel in, one pooled pixel out per
// completed window, with a per-output-column accumulator bank.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_PRECISION_1 = 3,
  parameter int CHANNELS              = 4,
  parameter int DATA_IN_0_WIDTH       = 8,
  parameter int DATA_IN_0_HEIGHT      = 8,
  parameter int KERNEL_WIDTH          = 2,
  parameter int KERNEL_HEIGHT         = 2,
  parameter int MODE                  = 0,
  parameter int RECIP_FRAC            = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [CHANNELS-1:0][DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                            data_in_0_valid,
  output logic                                            data_in_0_ready,
  output logic [CHANNELS-1:0][DATA_IN_0_PRECISION_0-1:0]  data_out_0,
  output logic                                            data_out_0_valid,
  input  logic                                            data_out_0_ready
);

  localparam int     P     = DATA_IN_0_PRECISION_0;
  localparam int     W     = DATA_IN_0_WIDTH;
  localparam int     H     = DATA_IN_0_HEIGHT;
  localparam int     KW    = KERNEL_WIDTH;
  localparam int     KH    = KERNEL_HEIGHT;
  localparam int     OUT_W = W / KW;
  localparam int     OUT_H = H / KH;
  localparam int     ACC_W = acc_width(P, KH, KW);
  localparam longint RECIP = recip_const(KH, KW, RECIP_FRAC);
  localparam int     CW    = $clog2(W + 1);
  localparam int     RW    = $clog2(H + 1);
  localparam int     KCW   = (KW > 1) ? $clog2(KW) : 1;
  localparam int     KRW   = (KH > 1) ? $clog2(KH) : 1;
  localparam int     OW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (KW > W || KH > H || DATA_IN_0_PRECISION_1 >= P) begin : g_bad_cfg
    $error("pool2d_stream: unsupported configuration");
  end

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [KCW-1:0] kc_q, kc_d;
  logic [KRW-1:0] kr_q, kr_d;
  logic [OW-1:0]  ocol_q, ocol_d;
  logic [OUT_W-1:0][CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [CHANNELS-1:0][ACC_W-1:0] comb;
  logic [CHANNELS-1:0][P-1:0]     res, dout_q, dout_d;
  logic vld_q, vld_d;
  logic fire, in_win, first, done;

  assign data_in_0_ready  = !vld_q || data_out_0_ready;
  assign fire             = data_in_0_valid && data_in_0_ready;
  assign in_win           = (col_q < CW'(OUT_W * KW)) && (row_q < RW'(OUT_H * KH));
  assign first            = (kc_q == '0) && (kr_q == '0);
  assign done             = in_win && (kc_q == KCW'(KW - 1)) && (kr_q == KRW'(KH - 1));
  assign data_out_0       = dout_q;
  assign data_out_0_valid = vld_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    pool_window_reduce #(
      .P(P), .ACC_W(ACC_W), .MODE(MODE), .RECIP_FRAC(RECIP_FRAC), .RECIP(RECIP)
    ) u_red (
      .pix(data_in_0[ch]), .acc_in(acc_q[ocol_q][ch]), .first(first),
      .acc_out(comb[ch]), .res(res[ch])
    );
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    kc_d   = kc_q;
    kr_d   = kr_q;
    ocol_d = ocol_q;
    if (fire) begin
      if (kc_q == KCW'(KW - 1)) begin
        kc_d = '0;
        // clamp so the trailing dropped columns never index past the bank
        if (ocol_q != OW'(OUT_W - 1)) ocol_d = ocol_q + OW'(1);
      end else begin
        kc_d = kc_q + KCW'(1);
      end
      if (col_q == CW'(W - 1)) begin
        col_d  = '0;
        kc_d   = '0;
        ocol_d = '0;
        kr_d   = (kr_q == KRW'(KH - 1)) ? '0 : kr_q + KRW'(1);
        if (row_q == RW'(H - 1)) begin
          row_d = '0;
          kr_d  = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (fire && in_win) acc_d[ocol_q] = comb;
    vld_d  = vld_q && !data_out_0_ready;
    dout_d = dout_q;
    if (fire && done) begin
      vld_d  = 1'b1;
      dout_d = res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      kc_q   <= '0;
      kr_q   <= '0;
      ocol_q <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      kc_q   <= kc_d;
      kr_q   <= kr_d;
      ocol_q <= ocol_d;
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

  // partials are always re-seeded on a window's first beat, so no reset needed
  always_ff @(posedge clk) acc_q <= acc_d;

endmodule

// File: tb/tb_pool2d_stream.sv
// Scoreboard bench: three pooling engines (avg 2x2, max 3x3, avg 3x3) on a shared 8x8x4 stream.
module tb_pool2d_stream;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][7:0] drv_data = '0;
  logic            drv_vld  = 1'b0;
  logic            out_rdy  = 1'b1;
  logic            rand_rdy = 1'b0;
  logic [ND-1:0]   in_rdy, in_vld, out_vld;
  logic [3:0][7:0] dout [ND];

  int checks = 0;
  int errors = 0;
  int frm [8][8][4];
  logic [3:0][7:0] exp_q [ND][$];
  logic            held   [ND];
  logic [3:0][7:0] held_d [ND];

  // a beat is taken only when every engine can take it, keeping the streams aligned
  assign in_vld[0] = drv_vld && in_rdy[1] && in_rdy[2];
  assign in_vld[1] = drv_vld && in_rdy[0] && in_rdy[2];
  assign in_vld[2] = drv_vld && in_rdy[0] && in_rdy[1];

  pool2d_stream u_avg2 (
    .clk(clk), .rst(rst), .data_in_0(drv_data), .data_in_0_valid(in_vld[0]),
    .data_in_0_ready(in_rdy[0]), .data_out_0(dout[0]), .data_out_0_valid(out_vld[0]),
    .data_out_0_ready(out_rdy)
  );

  pool2d_stream #(.KERNEL_WIDTH(3), .KERNEL_HEIGHT(3), .MODE(1)) u_max3 (
    .clk(clk), .rst(rst), .data_in_0(drv_data), .data_in_0_valid(in_vld[1]),
    .data_in_0_ready(in_rdy[1]), .data_out_0(dout[1]), .data_out_0_valid(out_vld[1]),
    .data_out_0_ready(out_rdy)
  );

  pool2d_stream #(.KERNEL_WIDTH(3), .KERNEL_HEIGHT(3), .MODE(0)) u_avg3 (
    .clk(clk), .rst(rst), .data_in_0(drv_data), .data_in_0_valid(in_vld[2]),
    .data_in_0_ready(in_rdy[2]), .data_out_0(dout[2]), .data_out_0_valid(out_vld[2]),
    .data_out_0_ready(out_rdy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic int kdim(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  // golden window result: exact round-half-up average or signed max
  function automatic logic [3:0][7:0] exp_px(input int d, input int oy, input int ox);
    logic [3:0][7:0] r;
    int k, s, m, v, num, den, q;
    k = kdim(d);
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      s = 0;
      m = -1000;
      for (int dy = 0; dy < k; dy++)
        for (int dx = 0; dx < k; dx++) begin
          v = frm[oy*k+dy][ox*k+dx][ch];
          s += v;
          if (v > m) m = v;
        end
      num = 2 * s + k * k;
      den = 2 * k * k;
      q = num / den;
      if ((num % den) != 0 && num < 0) q -= 1;
      r[ch] = (d == 1) ? 8'(m) : 8'(q);
    end
    return r;
  endfunction

  task automatic build_frame(input int kind);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (kind == 0) begin
          frm[r][c][0] = r * 8 + c;
          frm[r][c][1] = -(r * 8 + c);
          frm[r][c][2] = -1 - (r % 2);
          frm[r][c][3] = (r < 4) ? 127 : (((r % 2) == 1 && (c % 2) == 1) ? -2 : -1);
        end else begin
          for (int ch = 0; ch < 4; ch++) frm[r][c][ch] = int'($urandom_range(0, 255)) - 128;
        end
  endtask

  // queue every window whose completing beat lies within the first nbeats beats
  task automatic push_expected(input int nbeats);
    int k, last;
    for (int d = 0; d < ND; d++) begin
      k = kdim(d);
      for (int oy = 0; oy < 8 / k; oy++)
        for (int ox = 0; ox < 8 / k; ox++) begin
          last = (oy * k + k - 1) * 8 + ox * k + k - 1;
          if (last < nbeats) exp_q[d].push_back(exp_px(d, oy, ox));
        end
    end
  endtask

  // called on a negedge; returns on the negedge after the beat was accepted
  task automatic send(input int r, input int c);
    int n;
    for (int ch = 0; ch < 4; ch++) drv_data[ch] = 8'(frm[r][c][ch]);
    drv_vld = 1'b1;
    n = 0;
    while (!(&in_rdy)) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat (%0d,%0d) not accepted, expected acceptance", r, c);
        break;
      end
    end
    @(negedge clk);
    drv_vld = 1'b0;
  endtask

  task automatic send_frame(input int nbeats);
    for (int i = 0; i < nbeats; i++) send(i / 8, i % 8);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    for (int d = 0; d < ND; d++) held[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (!rst) begin
          held[d] = 1'b0;
        end else begin
          if (held[d]) begin
            check($sformatf("stall_valid%0d", d), 32'(out_vld[d]), 32'd1);
            check($sformatf("stall_data%0d", d), 32'(dout[d]), 32'(held_d[d]));
          end
          if (out_vld[d] && out_rdy) begin
            if (exp_q[d].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out%0d: got %h, expected no output", d, dout[d]);
            end else begin
              check($sformatf("out%0d", d), 32'(dout[d]), 32'(exp_q[d].pop_front()));
            end
          end
          held[d]   = out_vld[d] && !out_rdy;
          held_d[d] = dout[d];
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset_valid%0d", d), 32'(out_vld[d]), 32'd0);
      check($sformatf("reset_data%0d", d), 32'(dout[d]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // directed frame at full rate, then three random back-to-back frames under random stall
    build_frame(0);
    push_expected(64);
    send_frame(64);
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      build_frame(1);
      push_expected(64);
      send_frame(64);
    end

    // abandon a frame after 10 beats
    build_frame(1);
    push_expected(10);
    send_frame(10);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      check($sformatf("midreset_valid%0d", d), 32'(out_vld[d]), 32'd0);
    @(negedge clk);
    for (int d = 0; d < ND; d++) exp_q[d].delete();
    rst = 1'b1;
    @(negedge clk);

    build_frame(1);
    push_expected(64);
    send_frame(64);

    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    for (int d = 0; d < ND; d++)
      check($sformatf("drain%0d", d), 32'(exp_q[d].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
